// File: rtl/cgra_pkg.sv
// Shared CGRA configuration constants and the context-memory controller state type.
package cgra_pkg;

    localparam int unsigned N_ROW                = 4;
    localparam int unsigned IMEM_N_LINES         = 16;
    localparam int unsigned IMEM_N_LINES_LOG2    = $clog2(IMEM_N_LINES);
    localparam int unsigned DATA_BUS_DATA_WIDTH  = 32;
    localparam int unsigned CMEM_RET_IDLE_CYCLES = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
`ifdef CMEM_RETENTION_EN
        ,
        RET   = 2'd3
`endif
    } cmem_ctrl_state_t;

endpackage

// File: rtl/cmem_ctrl_if.sv
// Bus bundle between a host (load/exec side plus memory observer) and cmem_ctrl.
// The slave modport is the controller's view; master is the host/bench view.
interface cmem_ctrl_if #(
    parameter int unsigned N_ROW = cgra_pkg::N_ROW
);
    import cgra_pkg::*;

    // load side
    logic                           load_req_i;
    logic [N_ROW-1:0]               load_row_i;
    logic [IMEM_N_LINES_LOG2-1:0]   load_addr_i;
    logic [DATA_BUS_DATA_WIDTH-1:0] load_wdata_i;
    logic                           load_gnt_o;

    // execution side
    logic                           exec_start_i;
    logic [IMEM_N_LINES_LOG2-1:0]   exec_base_i;
    logic [IMEM_N_LINES_LOG2:0]     exec_len_i;
    logic                           exec_stall_i;
    logic                           exec_busy_o;
    logic                           instr_valid_o;
    logic                           exec_done_o;

    // memory side
    logic [N_ROW-1:0]               cm_row_req_o;
    logic                           cm_we_o;
    logic [IMEM_N_LINES_LOG2-1:0]   cm_addr_o;
    logic [DATA_BUS_DATA_WIDTH-1:0] cm_wdata_o;
    logic                           cm_clk_en_o;
    logic                           cm_set_retentive_o;

    modport slave (
        input  load_req_i, load_row_i, load_addr_i, load_wdata_i,
        output load_gnt_o,
        input  exec_start_i, exec_base_i, exec_len_i, exec_stall_i,
        output exec_busy_o, instr_valid_o, exec_done_o,
        output cm_row_req_o, cm_we_o, cm_addr_o, cm_wdata_o,
        output cm_clk_en_o, cm_set_retentive_o
    );

    modport master (
        output load_req_i, load_row_i, load_addr_i, load_wdata_i,
        input  load_gnt_o,
        output exec_start_i, exec_base_i, exec_len_i, exec_stall_i,
        input  exec_busy_o, instr_valid_o, exec_done_o,
        input  cm_row_req_o, cm_we_o, cm_addr_o, cm_wdata_o,
        input  cm_clk_en_o, cm_set_retentive_o
    );

endinterface

// File: rtl/cmem_ctrl_idle_timer.sv
// Idle-cycle counter for context-memory retention entry.
// expired_o fires on the cycle that completes RET_IDLE_CYCLES consecutive idle cycles.
module cmem_idle_timer #(
    parameter int unsigned RET_IDLE_CYCLES = cgra_pkg::CMEM_RET_IDLE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic count_en_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(RET_IDLE_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // next count: advance while idle, clear on any activity
    always_comb begin
        cnt_d = '0;
        if (count_en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign expired_o = count_en_i && (cnt_q == CNT_W'(RET_IDLE_CYCLES - 1));

    // idle counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cmem_ctrl.sv
// Context-memory controller: arbitrates bus loads into per-row context memories
// and sequences kernel instruction fetch with a 1-cycle SRAM read latency.
// Optional memory retention after a long idle period is enabled by defining
// the macro CMEM_RETENTION_EN.
module cmem_ctrl
    import cgra_pkg::*;
#(
    parameter int unsigned N_ROW           = cgra_pkg::N_ROW,
    parameter int unsigned RET_IDLE_CYCLES = cgra_pkg::CMEM_RET_IDLE_CYCLES
) (
    input  logic         clk_i,
    input  logic         rst_i,
    cmem_ctrl_if.slave   bus
);

    localparam int unsigned PC_W  = IMEM_N_LINES_LOG2;
    localparam int unsigned REM_W = IMEM_N_LINES_LOG2 + 1;

    if (RET_IDLE_CYCLES == 0) begin : g_bad_ret_cycles
        $error("cmem_ctrl: RET_IDLE_CYCLES must be non-zero");
    end

    cmem_ctrl_state_t   state_q;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pc_d;
    logic [REM_W-1:0]   rem_q;
    logic               valid_q;
    logic               done_q;
    logic               busy_q;

    logic                           gnt;
    logic [N_ROW-1:0]               row_req;
    logic                           we;
    logic [PC_W-1:0]                addr;
    logic [DATA_BUS_DATA_WIDTH-1:0] wdata;
    logic                           clk_en;
    logic                           retentive;
    logic                           any_req;
    logic                           ret_enter;

    assign any_req = bus.load_req_i || bus.exec_start_i;

`ifdef CMEM_RETENTION_EN
    logic idle_count_en;

    assign idle_count_en = (state_q == IDLE) && !any_req;

    cmem_idle_timer #(
        .RET_IDLE_CYCLES (RET_IDLE_CYCLES)
    ) u_idle_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .count_en_i (idle_count_en),
        .expired_o  (ret_enter)
    );
`else
    assign ret_enter = 1'b0;
`endif

    // program counter increment with explicit wrap at the last line
    always_comb begin
        pc_d = pc_q + PC_W'(1);
        if (pc_q == PC_W'(IMEM_N_LINES - 1)) begin
            pc_d = '0;
        end
    end

    // memory-side drive and load grant, combinational from state and inputs
    always_comb begin
        gnt       = 1'b0;
        row_req   = '0;
        we        = 1'b0;
        addr      = '0;
        wdata     = '0;
        clk_en    = 1'b0;
        retentive = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.load_req_i && !bus.exec_start_i) begin
                    gnt     = 1'b1;
                    row_req = bus.load_row_i;
                    we      = 1'b1;
                    addr    = bus.load_addr_i;
                    wdata   = bus.load_wdata_i;
                end
            end
            FETCH: begin
                clk_en = 1'b1;
                if (!bus.exec_stall_i) begin
                    row_req = '1;
                    addr    = pc_q;
                end
            end
            DRAIN: begin
                clk_en = 1'b1;
            end
`ifdef CMEM_RETENTION_EN
            // a request here is the wake cycle: leave retention, grant nothing
            RET: begin
                retentive = !any_req;
            end
`endif
            default: begin
            end
        endcase
        if (row_req != '0) begin
            clk_en = 1'b1;
        end
    end

    // control FSM with registered valid/done/busy flags
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pc_q    <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.exec_start_i) begin
                        if (bus.exec_len_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            pc_q    <= bus.exec_base_i;
                            rem_q   <= bus.exec_len_i;
                            state_q <= FETCH;
                            busy_q  <= 1'b1;
                        end
                    end else if (ret_enter) begin
`ifdef CMEM_RETENTION_EN
                        state_q <= RET;
`endif
                    end
                end
                FETCH: begin
                    if (!bus.exec_stall_i) begin
                        valid_q <= 1'b1;
                        pc_q    <= pc_d;
                        rem_q   <= rem_q - REM_W'(1);
                        // done is raised together with the final read's valid
                        if (rem_q == REM_W'(1)) begin
                            state_q <= DRAIN;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
`ifdef CMEM_RETENTION_EN
                RET: begin
                    if (any_req) begin
                        state_q <= IDLE;
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.load_gnt_o         = gnt;
    assign bus.cm_row_req_o       = row_req;
    assign bus.cm_we_o            = we;
    assign bus.cm_addr_o          = addr;
    assign bus.cm_wdata_o         = wdata;
    assign bus.cm_clk_en_o        = clk_en;
    assign bus.cm_set_retentive_o = retentive;
    assign bus.instr_valid_o      = valid_q;
    assign bus.exec_done_o        = done_q;
    assign bus.exec_busy_o        = busy_q;

endmodule

// File: tb/tb_cmem_ctrl.sv
// Directed, scoreboard-based bench for cmem_ctrl (retention steps built with CMEM_RETENTION_EN).
module tb_cmem_ctrl;
    import cgra_pkg::*;

    localparam int unsigned NR = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int total = 0;
    int bad   = 0;

    logic [IMEM_N_LINES_LOG2-1:0] exp_q[$];

    cmem_ctrl_if #(.N_ROW(NR)) bus ();

    cmem_ctrl #(
        .N_ROW           (NR),
        .RET_IDLE_CYCLES (64)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        bus.load_req_i   = 1'b0;
        bus.load_row_i   = '0;
        bus.load_addr_i  = '0;
        bus.load_wdata_i = '0;
        bus.exec_start_i = 1'b0;
        bus.exec_base_i  = '0;
        bus.exec_len_i   = '0;
        bus.exec_stall_i = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},   64'(bus.load_gnt_o), 64'd0);
        check({tag, "_row"},   64'(bus.cm_row_req_o), 64'd0);
        check({tag, "_we"},    64'(bus.cm_we_o), 64'd0);
        check({tag, "_clken"}, 64'(bus.cm_clk_en_o), 64'd0);
        check({tag, "_ret"},   64'(bus.cm_set_retentive_o), 64'd0);
        check({tag, "_valid"}, 64'(bus.instr_valid_o), 64'd0);
        check({tag, "_done"},  64'(bus.exec_done_o), 64'd0);
        check({tag, "_busy"},  64'(bus.exec_busy_o), 64'd0);
    endtask

    // Start a kernel and follow it to completion, comparing read addresses
    // against the scoreboard and counting valid cycles.
    task automatic run_fetch(input logic [IMEM_N_LINES_LOG2-1:0] base,
                             input logic [IMEM_N_LINES_LOG2:0] len,
                             input int stall_cycles, input bit contend);
        int reads = 0;
        int valids = 0;
        int stall_left = 0;
        bit done = 1'b0;
        bit stall_armed = (stall_cycles > 0);
        logic [IMEM_N_LINES_LOG2-1:0] b;
        b = base;
        for (int unsigned i = 0; i < 32'(len); i++) begin
            exp_q.push_back(b);
            b = b + 1'b1;
        end
        bus.exec_start_i = 1'b1;
        bus.exec_base_i  = base;
        bus.exec_len_i   = len;
        if (contend) begin
            bus.load_req_i   = 1'b1;
            bus.load_row_i   = 4'b1111;
            bus.load_addr_i  = 4'd9;
            bus.load_wdata_i = 32'h1234_5678;
        end
        @(negedge clk);
        if (contend) begin
            check("contend_gnt", 64'(bus.load_gnt_o), 64'd0);
            check("contend_row", 64'(bus.cm_row_req_o), 64'd0);
        end
        next_cycle();
        drive_idle();
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 0) check("fetch_busy", 64'(bus.exec_busy_o), 64'd1);
            if (stall_left > 0) check("stall_gap", 64'(bus.cm_row_req_o), 64'd0);
            if (bus.cm_row_req_o != '0) begin
                check("read_row", 64'(bus.cm_row_req_o), 64'hF);
                check("read_we", 64'(bus.cm_we_o), 64'd0);
                if (exp_q.size() == 0) begin
                    check("extra_read", 64'(bus.cm_addr_o), 64'hFFFF);
                end else begin
                    check("read_addr", 64'(bus.cm_addr_o), 64'(exp_q.pop_front()));
                end
                reads++;
            end
            if (bus.instr_valid_o) valids++;
            if (bus.exec_done_o) begin
                check("done_with_valid", 64'(bus.instr_valid_o), 64'd1);
                check("valid_count", 64'(valids), 64'(len));
                done = 1'b1;
            end
            next_cycle();
            if (stall_left > 0) stall_left--;
            if (stall_armed && reads == 1) begin
                stall_left  = stall_cycles;
                stall_armed = 1'b0;
            end
            bus.exec_stall_i = (stall_left > 0);
        end
        check("done_seen", 64'(done), 64'd1);
        check("sb_empty", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        check("busy_after", 64'(bus.exec_busy_o), 64'd0);
        exp_q.delete();
        next_cycle();
    endtask

    initial begin
        int seen_done;
        int seen_valid;
        drive_idle();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // load write
        next_cycle();
        bus.load_req_i   = 1'b1;
        bus.load_row_i   = 4'b0101;
        bus.load_addr_i  = 4'd3;
        bus.load_wdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        check("load_gnt",   64'(bus.load_gnt_o), 64'd1);
        check("load_row",   64'(bus.cm_row_req_o), 64'h5);
        check("load_we",    64'(bus.cm_we_o), 64'd1);
        check("load_addr",  64'(bus.cm_addr_o), 64'd3);
        check("load_wdata", 64'(bus.cm_wdata_o), 64'hDEAD_BEEF);
        check("load_clken", 64'(bus.cm_clk_en_o), 64'd1);

        // zero-mask load: granted, no row request, clock gate stays off
        next_cycle();
        bus.load_row_i = '0;
        @(negedge clk);
        check("zmask_gnt",   64'(bus.load_gnt_o), 64'd1);
        check("zmask_row",   64'(bus.cm_row_req_o), 64'd0);
        check("zmask_clken", 64'(bus.cm_clk_en_o), 64'd0);
        next_cycle();
        drive_idle();

        // plain fetch, wrap with stall, contention
        run_fetch(4'd5, 5'd4, 0, 1'b0);
        run_fetch(4'(IMEM_N_LINES - 2), 5'd3, 2, 1'b0);
        run_fetch(4'd2, 5'd2, 0, 1'b1);

        // zero-length kernel
        bus.exec_start_i = 1'b1;
        bus.exec_base_i  = 4'd7;
        bus.exec_len_i   = '0;
        next_cycle();
        drive_idle();
        @(negedge clk);
        check("zlen_done",  64'(bus.exec_done_o), 64'd1);
        check("zlen_row",   64'(bus.cm_row_req_o), 64'd0);
        check("zlen_busy",  64'(bus.exec_busy_o), 64'd0);
        check("zlen_valid", 64'(bus.instr_valid_o), 64'd0);
        next_cycle();
        @(negedge clk);
        check("zlen_done_off", 64'(bus.exec_done_o), 64'd0);

        // reset in the middle of a fetch
        next_cycle();
        bus.exec_start_i = 1'b1;
        bus.exec_base_i  = 4'd0;
        bus.exec_len_i   = 5'd8;
        next_cycle();
        drive_idle();
        next_cycle();
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        seen_done = 0;
        seen_valid = 0;
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            @(negedge clk);
            if (bus.exec_done_o) seen_done++;
            if (bus.instr_valid_o) seen_valid++;
        end
        check("midrst_no_done",  64'(seen_done), 64'd0);
        check("midrst_no_valid", 64'(seen_valid), 64'd0);

`ifdef CMEM_RETENTION_EN
        begin
            int idle_n = 0;
            next_cycle();
            bus.load_req_i = 1'b1;
            bus.load_row_i = 4'b0001;
            next_cycle();
            drive_idle();
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (bus.cm_set_retentive_o) break;
                idle_n++;
                next_cycle();
            end
            check("ret_idle_cycles", 64'(idle_n), 64'd64);
            check("ret_flag",  64'(bus.cm_set_retentive_o), 64'd1);
            check("ret_clken", 64'(bus.cm_clk_en_o), 64'd0);
            next_cycle();
            bus.load_req_i   = 1'b1;
            bus.load_row_i   = 4'b0010;
            bus.load_addr_i  = 4'd1;
            bus.load_wdata_i = 32'hCAFE_F00D;
            @(negedge clk);
            check("wake_ret", 64'(bus.cm_set_retentive_o), 64'd0);
            check("wake_gnt", 64'(bus.load_gnt_o), 64'd0);
            check("wake_row", 64'(bus.cm_row_req_o), 64'd0);
            next_cycle();
            @(negedge clk);
            check("post_wake_gnt", 64'(bus.load_gnt_o), 64'd1);
            check("post_wake_row", 64'(bus.cm_row_req_o), 64'h2);
            next_cycle();
            drive_idle();
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmem_ctrl.md
CMEM_CTRL -- requirements
Module: cmem_ctrl

Interface
REQ-001 SHALL have parameter N_ROW, default cgra_pkg::N_ROW (4), number of per-row context memories.
REQ-002 SHALL have parameter RET_IDLE_CYCLES, default cgra_pkg::CMEM_RET_IDLE_CYCLES (64), idle cycles before retention.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk_i in 1 (clock, all logic on rising edge); rst_i in 1 (synchronous, active-high reset).
REQ-004 SHALL have the following load ports:
- load_req_i in 1: bus write request.
- load_row_i in N_ROW: row mask for the write.
- load_addr_i in IMEM_N_LINES_LOG2: line address.
- load_wdata_i in DATA_BUS_DATA_WIDTH: instruction word.
- load_gnt_o out 1: write accepted this cycle.
REQ-005 SHALL have the following execution ports:
- exec_start_i in 1: start kernel fetch.
- exec_base_i in IMEM_N_LINES_LOG2: first line.
- exec_len_i in IMEM_N_LINES_LOG2+1: line count.
- exec_stall_i in 1: hold fetch.
- exec_busy_o out 1: fetch in progress.
- instr_valid_o out 1: memory rdata valid this cycle.
- exec_done_o out 1: one-cycle completion pulse.
REQ-006 SHALL have the following memory-side ports:
- cm_row_req_o out N_ROW: per-row request.
- cm_we_o out 1: write enable.
- cm_addr_o out IMEM_N_LINES_LOG2: address.
- cm_wdata_o out DATA_BUS_DATA_WIDTH: write data.
- cm_clk_en_o out 1: enable for the external clock gate.
- cm_set_retentive_o out 1: retention control.

Function
REQ-007 SHALL implement states IDLE, FETCH, DRAIN and RET (RET only with the macro of REQ-021).
REQ-008 In IDLE, exec_start_i SHALL load pc<=exec_base_i and rem<=exec_len_i, then go to FETCH; if exec_len_i==0, it SHALL stay in IDLE and pulse exec_done_o in the next cycle.
REQ-009 In IDLE with load_req_i=1 and exec_start_i=0, load_gnt_o SHALL be 1 combinationally and the block SHALL drive cm_row_req_o=load_row_i, cm_we_o=1, cm_addr_o=load_addr_i and cm_wdata_o=load_wdata_i in the same cycle; a zero mask is granted with no row request.
REQ-010 Simultaneous exec_start_i and load_req_i in IDLE: start SHALL win, and load_gnt_o SHALL be 0.
REQ-011 In FETCH with exec_stall_i=0, the block SHALL drive cm_row_req_o all-ones, cm_we_o=0 and cm_addr_o=pc, then pc++ and rem--.
REQ-012 In FETCH with exec_stall_i=1, there SHALL be no row request and pc/rem SHALL hold.
REQ-013 pc SHALL wrap from IMEM_N_LINES-1 to 0.
REQ-014 When the read with rem==1 is issued, the FSM SHALL go to DRAIN.
REQ-015 instr_valid_o SHALL be 1 exactly one cycle after each issued read (1-cycle SRAM latency).
REQ-016 DRAIN SHALL last one cycle, assert exec_done_o (coincident with the last instr_valid_o), then return to IDLE.
REQ-017 exec_busy_o SHALL be 1 in FETCH and DRAIN, where load_gnt_o=0 and exec_start_i is ignored.
REQ-018 cm_clk_en_o SHALL be 1 in any cycle with a non-zero cm_row_req_o, and throughout FETCH and DRAIN.
REQ-019 Memory-side outputs and load_gnt_o SHALL be combinational from state/registers/inputs; instr_valid_o, exec_done_o and exec_busy_o SHALL be registered.

Reset
REQ-020 On rst_i=1 the block SHALL enter IDLE with pc, rem and the idle counter at 0, and all outputs 0 in the following cycle; reset mid-FETCH SHALL abort without an exec_done_o pulse and drop any pending instr_valid_o.

Configuration
REQ-021 With macro CMEM_RETENTION_EN defined:
- IDLE cycles with no load_req_i/exec_start_i SHALL count; the count clears on any request.
- Reaching RET_IDLE_CYCLES SHALL enter RET with cm_set_retentive_o=1 and cm_clk_en_o=0.
- Any request in RET SHALL cause one wake cycle (retentive=0, load_gnt_o=0, start not accepted, requester must hold), then IDLE.
REQ-022 Without CMEM_RETENTION_EN, cm_set_retentive_o SHALL be tied 0, and no counter or RET state SHALL exist.

Structure
REQ-023 cgra_pkg SHALL hold N_ROW, IMEM_N_LINES, IMEM_N_LINES_LOG2, DATA_BUS_DATA_WIDTH, CMEM_RET_IDLE_CYCLES and enum cmem_ctrl_state_t.
REQ-024 The idle counter SHALL be sub-module cmem_idle_timer, instantiated only under CMEM_RETENTION_EN.

Verification
REQ-025 The bench SHALL cover the following scenarios:
- Load: load_req_i=1, load_row_i=4'b0101, addr=3, wdata=0xDEADBEEF -> same-cycle gnt, cm_row_req_o=0101, cm_we_o=1, cm_addr_o=3.
- Fetch: start base=5, len=4 -> reads at 5,6,7,8 on consecutive cycles; instr_valid_o 4 cycles; exec_done_o with the 4th valid.
- Wrap and stall: base=IMEM_N_LINES-2, len=3, stall 2 cycles after the first read -> addresses N-2, N-1, 0; gaps during stall; valid count 3.
- Contention and zero length: start and load in the same cycle -> gnt=0, fetch proceeds; len=0 -> done pulse next cycle, no reads.
- Reset mid-fetch: rst_i pulse during FETCH -> IDLE, no done pulse, all outputs 0.
- Retention (macro on): 64 idle cycles -> cm_set_retentive_o=1; load_req_i -> one wake cycle, then gnt.
